// File: rtl/axis_demux_4.sv
// AXI4-Stream 1-to-4 frame demultiplexer with a registered skid-buffer output stage.
// Optional frame discard is enabled by defining AXIS_DEMUX_DROP_EN (adds the drop input).
module axis_demux_4 #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned USER_ENABLE = 1,
   parameter int unsigned USER_WIDTH  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] input_axis_tdata,
   input  logic                  input_axis_tvalid,
   output logic                  input_axis_tready,
   input  logic                  input_axis_tlast,
   input  logic [USER_WIDTH-1:0] input_axis_tuser,
   output logic [DATA_WIDTH-1:0] output_0_axis_tdata,
   output logic                  output_0_axis_tvalid,
   input  logic                  output_0_axis_tready,
   output logic                  output_0_axis_tlast,
   output logic [USER_WIDTH-1:0] output_0_axis_tuser,
   output logic [DATA_WIDTH-1:0] output_1_axis_tdata,
   output logic                  output_1_axis_tvalid,
   input  logic                  output_1_axis_tready,
   output logic                  output_1_axis_tlast,
   output logic [USER_WIDTH-1:0] output_1_axis_tuser,
   output logic [DATA_WIDTH-1:0] output_2_axis_tdata,
   output logic                  output_2_axis_tvalid,
   input  logic                  output_2_axis_tready,
   output logic                  output_2_axis_tlast,
   output logic [USER_WIDTH-1:0] output_2_axis_tuser,
   output logic [DATA_WIDTH-1:0] output_3_axis_tdata,
   output logic                  output_3_axis_tvalid,
   input  logic                  output_3_axis_tready,
   output logic                  output_3_axis_tlast,
   output logic [USER_WIDTH-1:0] output_3_axis_tuser,
   input  logic                  enable,
`ifdef AXIS_DEMUX_DROP_EN
   input  logic                  drop,
`endif
   input  logic [1:0]            select
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                state;
   logic [1:0]            select_reg;
   logic                  ready_reg;
   logic [3:0]            out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   logic [USER_WIDTH-1:0] out_user;
   logic [3:0]            temp_valid;
   logic [DATA_WIDTH-1:0] temp_data;
   logic                  temp_last;
   logic [USER_WIDTH-1:0] temp_user;

   logic [3:0]            port_ready_c;
   logic [3:0]            dest_c;
   logic [USER_WIDTH-1:0] in_user_c;
   logic                  start_c;
   logic                  accept_c;
   logic                  store_c;
   logic                  drain_c;
   logic                  out_free_c;
   logic                  active_next_c;
   logic                  drop_reg;
   logic                  drop_next_c;
   logic                  ready_next_c;

`ifdef AXIS_DEMUX_DROP_EN
   // Discard flag is latched with the route and held for the whole frame.
   assign drop_next_c = start_c ? drop : drop_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_reg <= 1'b0;
      end else begin
         drop_reg <= drop_next_c;
      end
   end
`else
   assign drop_next_c = 1'b0;
   assign drop_reg    = 1'b0;
`endif

   assign port_ready_c = {output_3_axis_tready, output_2_axis_tready,
                          output_1_axis_tready, output_0_axis_tready};
   assign dest_c       = 4'b0001 << select_reg;
   assign in_user_c    = (USER_ENABLE != 0) ? input_axis_tuser : USER_WIDTH'(0);
   assign start_c      = (state == IDLE) && enable && input_axis_tvalid && !ready_reg;
   assign accept_c     = input_axis_tvalid && ready_reg;
   assign store_c      = accept_c && !drop_reg;
   // Valid bits are one-hot per port, so a drain only counts on the port that owns the beat.
   assign drain_c      = |(out_valid & port_ready_c);
   assign out_free_c   = drain_c || (out_valid == 4'b0000);

   // Frame tracking and next-cycle input readiness.
   always_comb begin
      active_next_c = (state == ACTIVE);
      if (start_c) begin
         active_next_c = 1'b1;
      end else if ((state == ACTIVE) && accept_c && input_axis_tlast) begin
         active_next_c = 1'b0;
      end
      ready_next_c = active_next_c &&
                     (drop_next_c || drain_c ||
                      ((temp_valid == 4'b0000) && (out_valid == 4'b0000)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         select_reg <= 2'd0;
         ready_reg  <= 1'b0;
         out_valid  <= 4'b0000;
         out_data   <= DATA_WIDTH'(0);
         out_last   <= 1'b0;
         out_user   <= USER_WIDTH'(0);
         temp_valid <= 4'b0000;
         temp_data  <= DATA_WIDTH'(0);
         temp_last  <= 1'b0;
         temp_user  <= USER_WIDTH'(0);
      end else begin
         state     <= active_next_c ? ACTIVE : IDLE;
         ready_reg <= ready_next_c;
         if (start_c) begin
            select_reg <= select;
         end
         // Skid buffer: output register is refilled from temp first to keep beat order.
         if (out_free_c) begin
            if (temp_valid != 4'b0000) begin
               out_valid <= temp_valid;
               out_data  <= temp_data;
               out_last  <= temp_last;
               out_user  <= temp_user;
               if (store_c) begin
                  temp_valid <= dest_c;
                  temp_data  <= input_axis_tdata;
                  temp_last  <= input_axis_tlast;
                  temp_user  <= in_user_c;
               end else begin
                  temp_valid <= 4'b0000;
               end
            end else if (store_c) begin
               out_valid <= dest_c;
               out_data  <= input_axis_tdata;
               out_last  <= input_axis_tlast;
               out_user  <= in_user_c;
            end else begin
               out_valid <= 4'b0000;
            end
         end else if (store_c) begin
            temp_valid <= dest_c;
            temp_data  <= input_axis_tdata;
            temp_last  <= input_axis_tlast;
            temp_user  <= in_user_c;
         end
      end
   end

   assign input_axis_tready    = ready_reg;

   assign output_0_axis_tvalid = out_valid[0];
   assign output_1_axis_tvalid = out_valid[1];
   assign output_2_axis_tvalid = out_valid[2];
   assign output_3_axis_tvalid = out_valid[3];

   assign output_0_axis_tdata  = out_data;
   assign output_1_axis_tdata  = out_data;
   assign output_2_axis_tdata  = out_data;
   assign output_3_axis_tdata  = out_data;

   assign output_0_axis_tlast  = out_last;
   assign output_1_axis_tlast  = out_last;
   assign output_2_axis_tlast  = out_last;
   assign output_3_axis_tlast  = out_last;

   assign output_0_axis_tuser  = out_user;
   assign output_1_axis_tuser  = out_user;
   assign output_2_axis_tuser  = out_user;
   assign output_3_axis_tuser  = out_user;

endmodule

// File: tb/tb_axis_demux_4.sv
// Directed self-checking bench for axis_demux_4 (drop scenario only when AXIS_DEMUX_DROP_EN is defined).
module tb_axis_demux_4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data  = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_last  = 1'b0;
   logic [0:0] in_user  = 1'b0;
   logic       enable   = 1'b0;
   logic [1:0] select   = 2'd0;
   logic [3:0] out_ready = 4'b1111;
`ifdef AXIS_DEMUX_DROP_EN
   logic       drop = 1'b0;
`endif
   wire        in_ready;
   wire [3:0]  out_valid;
   wire [3:0]  out_last;
   wire [7:0]  out_data [4];
   wire [0:0]  out_user [4];

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      int         port;
      logic [7:0] data;
      logic       last;
      int         cyc;
   } beat_t;
   beat_t mon_q[$];

   always #5 clk = ~clk;

   axis_demux_4 dut (
      .clk                  (clk),
      .rst                  (rst),
      .input_axis_tdata     (in_data),
      .input_axis_tvalid    (in_valid),
      .input_axis_tready    (in_ready),
      .input_axis_tlast     (in_last),
      .input_axis_tuser     (in_user),
      .output_0_axis_tdata  (out_data[0]),
      .output_0_axis_tvalid (out_valid[0]),
      .output_0_axis_tready (out_ready[0]),
      .output_0_axis_tlast  (out_last[0]),
      .output_0_axis_tuser  (out_user[0]),
      .output_1_axis_tdata  (out_data[1]),
      .output_1_axis_tvalid (out_valid[1]),
      .output_1_axis_tready (out_ready[1]),
      .output_1_axis_tlast  (out_last[1]),
      .output_1_axis_tuser  (out_user[1]),
      .output_2_axis_tdata  (out_data[2]),
      .output_2_axis_tvalid (out_valid[2]),
      .output_2_axis_tready (out_ready[2]),
      .output_2_axis_tlast  (out_last[2]),
      .output_2_axis_tuser  (out_user[2]),
      .output_3_axis_tdata  (out_data[3]),
      .output_3_axis_tvalid (out_valid[3]),
      .output_3_axis_tready (out_ready[3]),
      .output_3_axis_tlast  (out_last[3]),
      .output_3_axis_tuser  (out_user[3]),
      .enable               (enable),
`ifdef AXIS_DEMUX_DROP_EN
      .drop                 (drop),
`endif
      .select               (select)
   );

   // Record every completed output handshake with its port and cycle number.
   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         for (int p = 0; p < 4; p++) begin
            if (out_valid[p] && out_ready[p]) begin
               mon_q.push_back('{p, out_data[p], out_last[p], cyc});
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until accepted; waited = edges until acceptance.
   task automatic send_beat(input logic [7:0] d, input logic last, output int waited);
      logic acc;
      in_data  = d;
      in_last  = last;
      in_user  = d[0];
      in_valid = 1'b1;
      waited   = 0;
      for (int i = 0; i < 40; i++) begin
         acc = in_ready;
         step();
         waited++;
         if (acc) break;
      end
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL accept_timeout data=%h got no accept after %0d cycles, required accept", d, waited);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if (out_valid !== 4'b0000) begin
         errors++;
         $display("FAIL reset_tvalid got %b required 0000", out_valid);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_tready got %b required 0", in_ready);
      end
      checks++;
      if (out_data[0] !== 8'h00) begin
         errors++;
         $display("FAIL reset_tdata got %h required 00", out_data[0]);
      end
      checks++;
      if (out_last !== 4'b0000) begin
         errors++;
         $display("FAIL reset_tlast got %b required 0000", out_last);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic_frame();
      logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      int         exp_w [4] = '{2, 1, 1, 1};
      int         w;
      out_ready = 4'b1111;
      enable    = 1'b1;
      select    = 2'd2;
      for (int i = 0; i < 4; i++) begin
         send_beat(d[i], (i == 3), w);
         if (i == 3) in_valid = 1'b0;
         checks++;
         if (w !== exp_w[i]) begin
            errors++;
            $display("FAIL basic_wait beat %0d got %0d required %0d", i, w, exp_w[i]);
         end
         checks++;
         if (out_valid !== 4'b0100) begin
            errors++;
            $display("FAIL basic_tvalid beat %0d got %b required 0100", i, out_valid);
         end
         checks++;
         if (out_data[2] !== d[i]) begin
            errors++;
            $display("FAIL basic_tdata beat %0d got %h required %h", i, out_data[2], d[i]);
         end
         checks++;
         if (out_last[2] !== (i == 3)) begin
            errors++;
            $display("FAIL basic_tlast beat %0d got %b required %b", i, out_last[2], (i == 3));
         end
         checks++;
         if (out_user[2] !== d[i][0]) begin
            errors++;
            $display("FAIL basic_tuser beat %0d got %b required %b", i, out_user[2], d[i][0]);
         end
      end
      step();
      checks++;
      if ((out_valid !== 4'b0000) || (in_ready !== 1'b0)) begin
         errors++;
         $display("FAIL basic_idle got tvalid=%b tready=%b required 0000/0", out_valid, in_ready);
      end
   endtask

   task automatic test_select_hold();
      logic [7:0] exp_d [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2};
      int         exp_p [5] = '{1, 1, 1, 3, 3};
      int         w;
      mon_q.delete();
      select = 2'd1;
      send_beat(8'hA1, 1'b0, w);
      select = 2'd3;
      send_beat(8'hA2, 1'b0, w);
      send_beat(8'hA3, 1'b1, w);
      send_beat(8'hB1, 1'b0, w);
      checks++;
      if (w !== 2) begin
         errors++;
         $display("FAIL select_bubble got %0d required 2", w);
      end
      send_beat(8'hB2, 1'b1, w);
      in_valid = 1'b0;
      repeat (3) step();
      checks++;
      if (mon_q.size() !== 5) begin
         errors++;
         $display("FAIL select_count got %0d required 5", mon_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if ((mon_q[i].port !== exp_p[i]) || (mon_q[i].data !== exp_d[i]) ||
                (mon_q[i].last !== (i == 2 || i == 4))) begin
               errors++;
               $display("FAIL select_beat %0d got port=%0d data=%h last=%b required port=%0d data=%h last=%b",
                        i, mon_q[i].port, mon_q[i].data, mon_q[i].last, exp_p[i], exp_d[i], (i == 2 || i == 4));
            end
         end
      end
   endtask

   task automatic test_back_pressure();
      logic [7:0] exp_d [6] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
      int         w;
      mon_q.delete();
      select    = 2'd0;
      out_ready = 4'b1110;
      send_beat(8'hC1, 1'b0, w);
      send_beat(8'hC2, 1'b0, w);
      in_data = 8'hC3;
      in_user = 1'b1;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ((in_ready !== 1'b0) || (out_valid !== 4'b0001) || (out_data[0] !== 8'hC1)) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got tready=%b tvalid=%b tdata=%h required 0/0001/c1",
                     i, in_ready, out_valid, out_data[0]);
         end
         step();
      end
      out_ready = 4'b1111;
      send_beat(8'hC3, 1'b0, w);
      checks++;
      if (w !== 2) begin
         errors++;
         $display("FAIL bp_resume_wait got %0d required 2", w);
      end
      send_beat(8'hC4, 1'b0, w);
      send_beat(8'hC5, 1'b0, w);
      send_beat(8'hC6, 1'b1, w);
      in_valid = 1'b0;
      repeat (3) step();
      checks++;
      if (mon_q.size() !== 6) begin
         errors++;
         $display("FAIL bp_count got %0d required 6", mon_q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if ((mon_q[i].port !== 0) || (mon_q[i].data !== exp_d[i]) || (mon_q[i].last !== (i == 5))) begin
               errors++;
               $display("FAIL bp_beat %0d got port=%0d data=%h last=%b required port=0 data=%h last=%b",
                        i, mon_q[i].port, mon_q[i].data, mon_q[i].last, exp_d[i], (i == 5));
            end
         end
         for (int i = 1; i < 6; i++) begin
            checks++;
            if (mon_q[i].cyc !== mon_q[i-1].cyc + 1) begin
               errors++;
               $display("FAIL bp_gap beat %0d got cycle %0d required %0d", i, mon_q[i].cyc, mon_q[i-1].cyc + 1);
            end
         end
      end
   endtask

   task automatic test_enable_gate();
      int w;
      mon_q.delete();
      enable   = 1'b0;
      select   = 2'd2;
      in_data  = 8'hD1;
      in_last  = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if ((in_ready !== 1'b0) || (out_valid !== 4'b0000)) begin
            errors++;
            $display("FAIL enable_gate cycle %0d got tready=%b tvalid=%b required 0/0000", i, in_ready, out_valid);
         end
      end
      enable = 1'b1;
      send_beat(8'hD1, 1'b1, w);
      checks++;
      if (w !== 2) begin
         errors++;
         $display("FAIL enable_bubble got %0d required 2", w);
      end
      send_beat(8'hD2, 1'b1, w);
      in_valid = 1'b0;
      checks++;
      if (w !== 2) begin
         errors++;
         $display("FAIL single_beat_bubble got %0d required 2", w);
      end
      repeat (3) step();
      checks++;
      if ((mon_q.size() !== 2) || (mon_q[0].data !== 8'hD1) || (mon_q[1].data !== 8'hD2) ||
          (mon_q[0].port !== 2) || (mon_q[1].port !== 2)) begin
         errors++;
         $display("FAIL single_beat_frames got %0d beats required D1,D2 on port 2", mon_q.size());
      end
   endtask

   task automatic test_mid_frame_reset();
      int w;
      mon_q.delete();
      select = 2'd3;
      send_beat(8'hE1, 1'b0, w);
      send_beat(8'hE2, 1'b0, w);
      rst      = 1'b1;
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      checks++;
      if ((out_valid !== 4'b0000) || (in_ready !== 1'b0) || (out_data[3] !== 8'h00)) begin
         errors++;
         $display("FAIL midreset_state got tvalid=%b tready=%b tdata=%h required 0000/0/00",
                  out_valid, in_ready, out_data[3]);
      end
      select = 2'd1;
      send_beat(8'hF1, 1'b0, w);
      checks++;
      if (w !== 2) begin
         errors++;
         $display("FAIL midreset_bubble got %0d required 2", w);
      end
      send_beat(8'hF2, 1'b1, w);
      in_valid = 1'b0;
      repeat (3) step();
      checks++;
      if ((mon_q.size() !== 3) ||
          (mon_q[0].port !== 3) || (mon_q[0].data !== 8'hE1) ||
          (mon_q[1].port !== 1) || (mon_q[1].data !== 8'hF1) ||
          (mon_q[2].port !== 1) || (mon_q[2].data !== 8'hF2) || (mon_q[2].last !== 1'b1)) begin
         errors++;
         $display("FAIL midreset_beats got %0d beats required E1@3,F1@1,F2@1", mon_q.size());
      end
   endtask

`ifdef AXIS_DEMUX_DROP_EN
   task automatic test_drop();
      int w;
      int exp_w [3] = '{2, 1, 1};
      logic [7:0] d [3] = '{8'h71, 8'h72, 8'h73};
      mon_q.delete();
      select = 2'd0;
      drop   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send_beat(d[i], (i == 2), w);
         checks++;
         if ((w !== exp_w[i]) || (out_valid !== 4'b0000)) begin
            errors++;
            $display("FAIL drop_beat %0d got wait=%0d tvalid=%b required %0d/0000", i, w, out_valid, exp_w[i]);
         end
      end
      drop = 1'b0;
      send_beat(8'h81, 1'b1, w);
      in_valid = 1'b0;
      checks++;
      if ((w !== 2) || (out_valid !== 4'b0001) || (out_data[0] !== 8'h81)) begin
         errors++;
         $display("FAIL drop_next got wait=%0d tvalid=%b tdata=%h required 2/0001/81", w, out_valid, out_data[0]);
      end
      repeat (3) step();
      checks++;
      if (mon_q.size() !== 1) begin
         errors++;
         $display("FAIL drop_count got %0d required 1", mon_q.size());
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_frame();
      test_select_hold();
      test_back_pressure();
      test_enable_gate();
      test_mid_frame_reset();
`ifdef AXIS_DEMUX_DROP_EN
      test_drop();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axis_demux_4.md
Name: axis_demux_4

Overview:
- AXI4-Stream 1-to-4 frame-aware demultiplexer; the splitting counterpart of the 4-port stream mux.
- Steers whole frames from a single input stream to one of four outputs.
- The route is chosen at frame start and held until the tlast beat is accepted.
- Registered skid-buffer output stage gives full throughput with registered input_axis_tready.

Parameters:
- DATA_WIDTH, 8, tdata width in bits (>=1)
- USER_ENABLE, 1, 1 = carry tuser through; 0 = output tuser tied 0
- USER_WIDTH, 1, tuser width in bits

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous active-high reset
- input_axis_tdata  input  DATA_WIDTH  input data
- input_axis_tvalid  input  1  input beat valid
- input_axis_tready  output  1  input beat accepted (registered)
- input_axis_tlast  input  1  last beat of frame
- input_axis_tuser  input  USER_WIDTH  sideband, forwarded per beat
- output_N_axis_tdata  output  DATA_WIDTH  (N=0..3) routed data, shared data register
- output_N_axis_tvalid  output  1  (N=0..3) valid; only the routed port is ever high
- output_N_axis_tready  input  1  (N=0..3) downstream ready
- output_N_axis_tlast  output  1  (N=0..3) routed tlast
- output_N_axis_tuser  output  USER_WIDTH  (N=0..3) routed tuser
- enable  input  1  permits a new frame to start
- select  input  2  destination port for the next frame

Behaviour:
- Reset:
  - All output_N_axis_tvalid=0 and input_axis_tready=0.
  - State IDLE, select_reg=0, temp/skid register empty.
  - tdata/tlast/tuser registers cleared to 0.
- States:
  - IDLE: no frame in progress.
  - ACTIVE: frame routed to select_reg.
- IDLE -> ACTIVE:
  - Condition: enable=1 && input_axis_tvalid=1 on a cycle with input_axis_tready=0.
  - Action: select_reg<=select.
  - Cost: one-cycle bubble before the first beat is accepted.
  - enable=0 holds IDLE with input_axis_tready=0 regardless of tvalid.
- ACTIVE -> IDLE:
  - Occurs on the cycle a beat with input_axis_tlast=1 is accepted (tvalid&&tready).
  - select and enable are ignored while ACTIVE. Changing them mid-frame has no effect on the current frame.
- Single-beat frames:
  - A frame that starts and ends on one beat returns to IDLE.
  - The next frame takes its own one-cycle select bubble.
- input_axis_tready (registered):
  - Next value = next-state ACTIVE && (output_N tready for N=select_reg || (temp empty && (output reg empty || output tvalid low))).
- Skid buffer:
  - Accepted beats go to the output register if it is empty or being drained; otherwise to the temp register.
  - Temp refills the output register when the routed port's tready=1.
  - No beat is ever lost or duplicated.
- Latency and throughput:
  - Latency: 1 cycle from input accept to output_N tvalid.
  - Sustained 1 beat/cycle when the routed port holds tready=1.
- Unrouted ports: tvalid stays 0; their tready is ignored.
- Beat ordering: tdata/tlast/tuser are stable while tvalid=1 && tready=0 (AXI rule).
- Reset mid-frame:
  - Partial frame discarded, buffered beats dropped, state IDLE.
  - Upstream must restart the frame.
- Back-pressure: routed tready=0 indefinitely -> at most 2 beats buffered, then input_axis_tready=0.

Optional Feature:
- Macro: AXIS_DEMUX_DROP_EN.
- With it defined:
  - Adds input port drop (1 bit), sampled together with select at IDLE->ACTIVE.
  - If drop=1, the whole frame is accepted at 1 beat/cycle (input_axis_tready=1 from the cycle after the bubble) up to and including tlast.
  - No output tvalid is raised for that frame.
- Without it:
  - No drop port; every frame is delivered to select_reg.

Test Plan:
- Reset, then enable=1, select=2, 4-beat frame 0x11,0x22,0x33,0x44 (tlast on 0x44), all tready=1 -> output_2 tvalid 1 cycle after each accept, data in order, tlast on 0x44; outputs 0/1/3 tvalid never high.
- Frame to select=1; change select to 3 after beat 1 of 3 -> all 3 beats on output_1; next frame goes to output_3.
- output_0 tready=0 for 6 cycles mid-frame -> exactly 2 beats buffered, input_axis_tready=0 after that; on release data resumes in order with no gap or duplicate.
- enable=0 with input tvalid=1 for 5 cycles -> input_axis_tready=0 throughout; after enable=1, 1-cycle bubble then accept.
- rst pulsed for one cycle during beat 2 of a 4-beat frame -> next cycle all tvalid=0, input_axis_tready=0, state IDLE; next frame routes per fresh select.
- AXIS_DEMUX_DROP_EN defined, drop=1, select=0, 3-beat frame -> 3 beats accepted back-to-back, no output tvalid; following frame with drop=0 delivered normally.
